// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bundle between the fetch stage and
// instruction memory. The fetch stage is the master: it issues a word
// request and address, memory answers with an ack and the read data.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the MIPS pipeline.
// Holds the PC, issues one outstanding word request at a time over a
// variable-latency req/ack handshake, and presents fetched words on a
// registered IF/ID output with a valid flag. Decode stalls park a word
// that arrives during the stall in a one-entry buffer; branch redirects
// flush IF/ID and win over stalls.
// Optional feature: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect sets a
// sticky error flag and parks the stage in HALT until reset. Without the
// macro the low two target bits are simply cleared.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  instruction_fetch_if.master   imem,
  output logic [31:0]           instruction,
  output logic [31:0]           pc_out,
  output logic [31:0]           pc_plus4,
  output logic                  if_valid,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_HALT  = 2'd3
`endif
  } fetch_state_t;

  fetch_state_t r_state;
  fetch_state_t w_state;

  logic [31:0] r_pc,      w_pc;
  logic [31:0] r_instr,   w_instr;
  logic [31:0] r_pcOut,   w_pcOut;
  logic [31:0] r_pcPlus4, w_pcPlus4;
  logic        r_valid,   w_valid;
  logic [31:0] r_bufInstr, w_bufInstr;
  logic [31:0] r_bufPc,    w_bufPc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_misalign, w_misalign;
  logic        w_halted;
`endif
  logic        w_ackSeen;

  // Memory acks only count while a request is actually outstanding.
  assign w_ackSeen = imem.imem_ack && (r_state == S_FETCH);

  // Next-state and next-register computation; every field defaults to hold.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_instr    = r_instr;
    w_pcOut    = r_pcOut;
    w_pcPlus4  = r_pcPlus4;
    w_valid    = r_valid;
    w_bufInstr = r_bufInstr;
    w_bufPc    = r_bufPc;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misalign = r_misalign;
    w_halted   = (r_state == S_HALT);
`endif

    // Redirect is checked first so it beats both stall and a same-cycle ack.
    if (branch_taken
`ifdef FETCH_MISALIGN_TRAP_EN
        && !w_halted
`endif
       ) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (branch_target[1:0] != 2'b00) begin
        w_misalign = 1'b1;
        w_valid    = 1'b0;
        w_state    = S_HALT;
      end else
`endif
      begin
        w_pc    = branch_target & ~32'd3;
        w_valid = 1'b0;
        w_instr = 32'd0;
        w_state = S_FETCH;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state = S_FETCH;
        end
        S_FETCH: begin
          if (w_ackSeen && !stall) begin
            w_instr   = imem.imem_rdata;
            w_pcOut   = r_pc;
            w_pcPlus4 = r_pc + 32'd4;
            w_valid   = 1'b1;
            w_pc      = r_pc + 32'd4;
          end else if (w_ackSeen && stall) begin
            w_bufInstr = imem.imem_rdata;
            w_bufPc    = r_pc;
            w_state    = S_HOLD;
          end else if (!stall) begin
            w_valid = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_instr   = r_bufInstr;
            w_pcOut   = r_bufPc;
            w_pcPlus4 = r_bufPc + 32'd4;
            w_valid   = 1'b1;
            w_pc      = r_bufPc + 32'd4;
            w_state   = S_FETCH;
          end
        end
        default: begin
          w_state = r_state;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_pcOut    <= 32'd0;
      r_pcPlus4  <= 32'd0;
      r_valid    <= 1'b0;
      r_bufInstr <= 32'd0;
      r_bufPc    <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_instr    <= w_instr;
      r_pcOut    <= w_pcOut;
      r_pcPlus4  <= w_pcPlus4;
      r_valid    <= w_valid;
      r_bufInstr <= w_bufInstr;
      r_bufPc    <= w_bufPc;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign <= w_misalign;
`endif
    end
  end

  assign imem.imem_req  = (r_state == S_FETCH);
  assign imem.imem_addr = r_pc;
  assign instruction    = r_instr;
  assign pc_out         = r_pcOut;
  assign pc_plus4       = r_pcPlus4;
  assign if_valid       = r_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_err   = r_misalign;
`else
  assign misalign_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. Words delivered to IF/ID are
// predicted into a scoreboard queue when the ack is driven and popped when
// the IF/ID register is expected to show them.
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        misalign_err;

  int passCount;
  int checkCount;
  exp_t sbQ[$];
  exp_t e;

  instruction_fetch_if imemIf ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imemIf.master),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .if_valid      (if_valid),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    stall             = 1'b0;
    branch_taken      = 1'b0;
    branch_target     = 32'd0;
    imemIf.imem_ack   = 1'b0;
    imemIf.imem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    step();
    step();
    checkCount++;
    if (instruction !== 32'd0 || pc_out !== 32'd0 || pc_plus4 !== 32'd0 || if_valid !== 1'b0 || misalign_err !== 1'b0) begin
      $display("[TB] FAIL reset_outputs: instr=%h pc_out=%h pc_plus4=%h valid=%b mis=%b, required all zero", instruction, pc_out, pc_plus4, if_valid, misalign_err);
    end else passCount++;
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (imemIf.imem_req !== 1'b0) begin
      $display("[TB] FAIL reset_idle_req: req=%b, required 0", imemIf.imem_req);
    end else passCount++;
    step();
    checkCount++;
    if (imemIf.imem_req !== 1'b1 || imemIf.imem_addr !== 32'd0) begin
      $display("[TB] FAIL first_request: req=%b addr=%h, required 1/00000000", imemIf.imem_req, imemIf.imem_addr);
    end else passCount++;
  endtask

  task automatic test_single_fetch();
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'h0443_0004;
    sbQ.push_back('{word: 32'h0443_0004, pc: 32'h0});
    step();
    imemIf.imem_ack = 1'b0;
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || pc_out !== e.pc || pc_plus4 !== e.pc + 32'd4 || if_valid !== 1'b1) begin
      $display("[TB] FAIL single_fetch: instr=%h pc_out=%h pc_plus4=%h valid=%b, required %h/%h/%h/1", instruction, pc_out, pc_plus4, if_valid, e.word, e.pc, e.pc + 32'd4);
    end else passCount++;
    checkCount++;
    if (imemIf.imem_addr !== 32'd4) begin
      $display("[TB] FAIL single_fetch_next_addr: addr=%h, required 00000004", imemIf.imem_addr);
    end else passCount++;
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      imemIf.imem_ack = 1'b0;
      step();
      checkCount++;
      if (if_valid !== 1'b0 || imemIf.imem_addr !== 32'd4 || imemIf.imem_req !== 1'b1) begin
        $display("[TB] FAIL wait_state_%0d: valid=%b addr=%h req=%b, required 0/00000004/1", i, if_valid, imemIf.imem_addr, imemIf.imem_req);
      end else passCount++;
    end
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'h2222_0004;
    sbQ.push_back('{word: 32'h2222_0004, pc: 32'h4});
    step();
    imemIf.imem_ack = 1'b0;
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || pc_out !== e.pc || if_valid !== 1'b1) begin
      $display("[TB] FAIL wait_state_delivery: instr=%h pc_out=%h valid=%b, required %h/%h/1", instruction, pc_out, if_valid, e.word, e.pc);
    end else passCount++;
  endtask

  task automatic test_stall_hold();
    stall             = 1'b1;
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'h1CB6_2C0A;
    step();
    imemIf.imem_ack = 1'b0;
    sbQ.push_back('{word: 32'h1CB6_2C0A, pc: 32'h8});
    for (int i = 0; i < 2; i++) begin
      checkCount++;
      if (instruction !== 32'h2222_0004 || pc_out !== 32'd4 || if_valid !== 1'b1 || imemIf.imem_req !== 1'b0) begin
        $display("[TB] FAIL stall_hold_%0d: instr=%h pc_out=%h valid=%b req=%b, required 22220004/00000004/1/0", i, instruction, pc_out, if_valid, imemIf.imem_req);
      end else passCount++;
      step();
    end
    stall = 1'b0;
    step();
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || pc_out !== e.pc || pc_plus4 !== e.pc + 32'd4 || if_valid !== 1'b1) begin
      $display("[TB] FAIL stall_release: instr=%h pc_out=%h pc_plus4=%h valid=%b, required %h/%h/%h/1", instruction, pc_out, pc_plus4, if_valid, e.word, e.pc, e.pc + 32'd4);
    end else passCount++;
    checkCount++;
    if (imemIf.imem_req !== 1'b1 || imemIf.imem_addr !== 32'd12) begin
      $display("[TB] FAIL stall_release_next_req: req=%b addr=%h, required 1/0000000c", imemIf.imem_req, imemIf.imem_addr);
    end else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expPc;
    expPc = 32'd12;
    for (int i = 0; i < 4; i++) begin
      imemIf.imem_ack   = 1'b1;
      imemIf.imem_rdata = 32'hA000_0000 + i;
      sbQ.push_back('{word: 32'hA000_0000 + i, pc: expPc});
      expPc = expPc + 32'd4;
      step();
      e = sbQ.pop_front();
      checkCount++;
      if (instruction !== e.word || pc_out !== e.pc || if_valid !== 1'b1 || imemIf.imem_addr !== expPc) begin
        $display("[TB] FAIL back_to_back_%0d: instr=%h pc_out=%h valid=%b addr=%h, required %h/%h/1/%h", i, instruction, pc_out, if_valid, imemIf.imem_addr, e.word, e.pc, expPc);
      end else passCount++;
    end
    imemIf.imem_ack = 1'b0;
  endtask

  task automatic test_branch_flush();
    // Redirect with a same-cycle ack: word must be discarded.
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'hDEAD_BEEF;
    branch_taken      = 1'b1;
    branch_target     = 32'h40;
    step();
    idleInputs();
    checkCount++;
    if (if_valid !== 1'b0 || instruction !== 32'd0 || imemIf.imem_addr !== 32'h40 || imemIf.imem_req !== 1'b1) begin
      $display("[TB] FAIL branch_flush: valid=%b instr=%h addr=%h req=%b, required 0/00000000/00000040/1", if_valid, instruction, imemIf.imem_addr, imemIf.imem_req);
    end else passCount++;
    // Fill IF/ID with a real word, then flush again under stall.
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'h1234_5678;
    sbQ.push_back('{word: 32'h1234_5678, pc: 32'h40});
    step();
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || pc_out !== e.pc || if_valid !== 1'b1) begin
      $display("[TB] FAIL target_word: instr=%h pc_out=%h valid=%b, required %h/%h/1", instruction, pc_out, if_valid, e.word, e.pc);
    end else passCount++;
    stall             = 1'b1;
    imemIf.imem_rdata = 32'hDEAD_BEEF;
    branch_taken      = 1'b1;
    branch_target     = 32'h40;
    step();
    idleInputs();
    checkCount++;
    if (if_valid !== 1'b0 || instruction !== 32'd0 || imemIf.imem_addr !== 32'h40 || imemIf.imem_req !== 1'b1) begin
      $display("[TB] FAIL branch_flush_stalled: valid=%b instr=%h addr=%h req=%b, required 0/00000000/00000040/1", if_valid, instruction, imemIf.imem_addr, imemIf.imem_req);
    end else passCount++;
  endtask

  task automatic test_pc_wrap();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    idleInputs();
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'h0BAD_F00D;
    sbQ.push_back('{word: 32'h0BAD_F00D, pc: 32'hFFFF_FFFC});
    step();
    imemIf.imem_ack = 1'b0;
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || pc_out !== e.pc || pc_plus4 !== 32'd0 || imemIf.imem_addr !== 32'd0) begin
      $display("[TB] FAIL pc_wrap: instr=%h pc_out=%h pc_plus4=%h addr=%h, required %h/%h/00000000/00000000", instruction, pc_out, pc_plus4, imemIf.imem_addr, e.word, e.pc);
    end else passCount++;
  endtask

  task automatic test_misalign();
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    step();
    idleInputs();
`ifdef FETCH_MISALIGN_TRAP_EN
    checkCount++;
    if (misalign_err !== 1'b1 || if_valid !== 1'b0) begin
      $display("[TB] FAIL misalign_trap: mis=%b valid=%b, required 1/0", misalign_err, if_valid);
    end else passCount++;
    for (int i = 0; i < 11; i++) begin
      imemIf.imem_ack = 1'b1;
      stall           = 1'($urandom_range(0, 1));
      branch_taken    = 1'b1;
      branch_target   = 32'h0;
      step();
      checkCount++;
      if (imemIf.imem_req !== 1'b0 || misalign_err !== 1'b1) begin
        $display("[TB] FAIL halt_cycle_%0d: req=%b mis=%b, required 0/1", i, imemIf.imem_req, misalign_err);
      end else passCount++;
    end
    idleInputs();
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (misalign_err !== 1'b0 || imemIf.imem_req !== 1'b0) begin
      $display("[TB] FAIL halt_reset: mis=%b req=%b, required 0/0", misalign_err, imemIf.imem_req);
    end else passCount++;
    step();
    rst_n = 1'b1;
    step();
`else
    checkCount++;
    if (imemIf.imem_addr !== 32'h40 || misalign_err !== 1'b0 || imemIf.imem_req !== 1'b1) begin
      $display("[TB] FAIL misalign_clear: addr=%h mis=%b req=%b, required 00000040/0/1", imemIf.imem_addr, misalign_err, imemIf.imem_req);
    end else passCount++;
`endif
  endtask

  task automatic test_reset_mid_request();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    idleInputs();
    imemIf.imem_rdata = 32'h5555_0040;
    imemIf.imem_ack   = 1'b1;
    sbQ.push_back('{word: 32'h5555_0040, pc: 32'h40});
    step();
    imemIf.imem_ack = 1'b0;
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || if_valid !== 1'b1) begin
      $display("[TB] FAIL pre_reset_word: instr=%h valid=%b, required %h/1", instruction, if_valid, e.word);
    end else passCount++;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (imemIf.imem_req !== 1'b0 || instruction !== 32'd0 || pc_out !== 32'd0 || pc_plus4 !== 32'd0 || if_valid !== 1'b0 || misalign_err !== 1'b0 || imemIf.imem_addr !== 32'd0) begin
      $display("[TB] FAIL async_reset: req=%b instr=%h pc_out=%h pc_plus4=%h valid=%b mis=%b addr=%h, required all zero", imemIf.imem_req, instruction, pc_out, pc_plus4, if_valid, misalign_err, imemIf.imem_addr);
    end else passCount++;
    step();
    rst_n = 1'b1;
    step();
    checkCount++;
    if (imemIf.imem_req !== 1'b1 || imemIf.imem_addr !== 32'd0) begin
      $display("[TB] FAIL restart_request: req=%b addr=%h, required 1/00000000", imemIf.imem_req, imemIf.imem_addr);
    end else passCount++;
    imemIf.imem_ack   = 1'b1;
    imemIf.imem_rdata = 32'h7777_0000;
    sbQ.push_back('{word: 32'h7777_0000, pc: 32'h0});
    step();
    imemIf.imem_ack = 1'b0;
    e = sbQ.pop_front();
    checkCount++;
    if (instruction !== e.word || pc_out !== e.pc || if_valid !== 1'b1) begin
      $display("[TB] FAIL restart_fetch: instr=%h pc_out=%h valid=%b, required %h/%h/1", instruction, pc_out, if_valid, e.word, e.pc);
    end else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    idleInputs();
    test_reset();
    test_single_fetch();
    test_wait_states();
    test_stall_hold();
    test_back_to_back();
    test_branch_flush();
    test_pc_wrap();
    test_misalign();
    test_reset_mid_request();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
